// File: rtl/seg_mux_capture_if.sv
// Bus bundle for the multiplexed 7-segment capture block: the sampled display
// bus on the input side and the decoded per-digit view on the output side.
interface seg_mux_capture_if;
  logic [7:0] iSEG;
  logic [2:0] iBAZA;
  logic [3:0] oDIG0;
  logic [3:0] oDIG1;
  logic [3:0] oDIG2;
  logic [2:0] oDP;
  logic [2:0] oVALID;
  logic [2:0] oERR;
  logic       oUPD;

  modport master (
    output iSEG, iBAZA,
    input  oDIG0, oDIG1, oDIG2, oDP, oVALID, oERR, oUPD
  );

  modport slave (
    input  iSEG, iBAZA,
    output oDIG0, oDIG1, oDIG2, oDP, oVALID, oERR, oUPD
  );
endinterface

// File: rtl/seg_mux_capture.sv
// Receiver for a 3-digit multiplexed 7-segment bus: synchronises, filters out
// transients, decodes each committed pattern to hex and keeps one value per digit.
module seg_mux_capture #(
  parameter int unsigned      STABLE_CYC = 4,
  parameter int unsigned      TO_W       = 24,
  parameter logic [TO_W-1:0]  TIMEOUT    = 24'd6000000
) (
  input  logic              iCLK,
  input  logic              iRST_N,
  seg_mux_capture_if.slave  bus
);

  localparam int unsigned     CNT_W    = $clog2(STABLE_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYC - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TIMEOUT - TO_W'(1);
  localparam logic [10:0]      BUS_IDLE = {3'b111, 8'h00};

  // Returns {known, value}; known=0 for any pattern that is not a hex glyph.
  function automatic logic [4:0] seg_decode(input logic [6:0] pat);
    logic [4:0] r;
    case (pat)
      7'h3F:   r = {1'b1, 4'h0};
      7'h06:   r = {1'b1, 4'h1};
      7'h5B:   r = {1'b1, 4'h2};
      7'h4F:   r = {1'b1, 4'h3};
      7'h66:   r = {1'b1, 4'h4};
      7'h6D:   r = {1'b1, 4'h5};
      7'h7D:   r = {1'b1, 4'h6};
      7'h07:   r = {1'b1, 4'h7};
      7'h7F:   r = {1'b1, 4'h8};
      7'h6F:   r = {1'b1, 4'h9};
      7'h77:   r = {1'b1, 4'hA};
      7'h7C:   r = {1'b1, 4'hB};
      7'h39:   r = {1'b1, 4'hC};
      7'h5E:   r = {1'b1, 4'hD};
      7'h79:   r = {1'b1, 4'hE};
      7'h71:   r = {1'b1, 4'hF};
      default: r = {1'b0, 4'h0};
    endcase
    return r;
  endfunction

  // One-hot digit target; blank and multi-zero selects address nothing.
  function automatic logic [2:0] sel_target(input logic [2:0] baza);
    logic [2:0] r;
    case (baza)
      3'b110:  r = 3'b001;
      3'b101:  r = 3'b010;
      3'b011:  r = 3'b100;
      default: r = 3'b000;
    endcase
    return r;
  endfunction

  logic [10:0]           sync1_q, sync1_d;
  logic [10:0]           sync2_q, sync2_d;
  logic [10:0]           prev_q, prev_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  armed_q, armed_d;
  logic [2:0][3:0]       dig_q, dig_d;
  logic [2:0]            dp_q, dp_d;
  logic [2:0]            valid_q, valid_d;
  logic [2:0]            err_q, err_d;
  logic                  upd_q, upd_d;
  logic [2:0][TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic                  same_s;
  logic                  commit_s;
  logic [2:0]            tgt_s;
  logic [4:0]            dec_s;

  // Synchroniser and stability filter; commit fires once per stable value.
  always_comb begin
    sync1_d  = {bus.iBAZA, bus.iSEG};
    sync2_d  = sync1_q;
    prev_d   = sync2_q;
    same_s   = (sync2_q == prev_q);
    commit_s = 1'b0;
    cnt_d    = cnt_q;
    armed_d  = armed_q;
    if (!same_s) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (armed_q) begin
      if (cnt_q == CNT_LAST) begin
        commit_s = 1'b1;
        armed_d  = 1'b0;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Per-digit update on commit, timeout ageing, and change detection for oUPD.
  always_comb begin
    tgt_s    = commit_s ? sel_target(sync2_q[10:8]) : 3'b000;
    dec_s    = seg_decode(sync2_q[6:0]);
    dig_d    = dig_q;
    dp_d     = dp_q;
    valid_d  = valid_q;
    err_d    = err_q;
    to_cnt_d = to_cnt_q;
    upd_d    = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (tgt_s[n]) begin
        to_cnt_d[n] = '0;
        if (dec_s[4]) begin
          dig_d[n]   = dec_s[3:0];
          dp_d[n]    = sync2_q[7];
          valid_d[n] = 1'b1;
          err_d[n]   = 1'b0;
        end else begin
          valid_d[n] = 1'b0;
          err_d[n]   = 1'b1;
        end
      end else if (to_cnt_q[n] == TO_LAST) begin
        // Counter reaches TIMEOUT on this edge: data is stale, value is kept.
        to_cnt_d[n] = TIMEOUT;
        valid_d[n]  = 1'b0;
      end else if (to_cnt_q[n] != TIMEOUT) begin
        to_cnt_d[n] = to_cnt_q[n] + TO_W'(1);
      end else begin
        to_cnt_d[n] = to_cnt_q[n];
      end
      if ({dig_d[n], dp_d[n], valid_d[n]} != {dig_q[n], dp_q[n], valid_q[n]}) begin
        upd_d = 1'b1;
      end else begin
        upd_d = upd_d;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      sync1_q  <= BUS_IDLE;
      sync2_q  <= BUS_IDLE;
      prev_q   <= BUS_IDLE;
      cnt_q    <= '0;
      armed_q  <= 1'b0;
      dig_q    <= '0;
      dp_q     <= 3'b000;
      valid_q  <= 3'b000;
      err_q    <= 3'b000;
      upd_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      cnt_q    <= cnt_d;
      armed_q  <= armed_d;
      dig_q    <= dig_d;
      dp_q     <= dp_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      upd_q    <= upd_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign bus.oDIG0  = dig_q[0];
  assign bus.oDIG1  = dig_q[1];
  assign bus.oDIG2  = dig_q[2];
  assign bus.oDP    = dp_q;
  assign bus.oVALID = valid_q;
  assign bus.oERR   = err_q;
  assign bus.oUPD   = upd_q;

endmodule
